// File: rtl/hamming_serial_rx_pkg.sv
// Shared types and constants for the serial Hamming(7,4) receiver.
// Code bit c[i-1] carries Hamming position i (p1,p2,d1,p3,d2,d3,d4).
package hamming_serial_rx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_DATA      = 2'd1,
        ST_STOP      = 2'd2,
        ST_WAIT_IDLE = 2'd3
    } rx_state_t;

    localparam int CODE_LEN = 7;
    localparam int DATA_W   = 4;

    localparam int D1_IDX = 2;
    localparam int D2_IDX = 4;
    localparam int D3_IDX = 5;
    localparam int D4_IDX = 6;

    function automatic logic [2:0] calc_syndrome(input logic [CODE_LEN-1:0] code);
        logic s1;
        logic s2;
        logic s3;
        s1 = code[0] ^ code[2] ^ code[4] ^ code[6];
        s2 = code[1] ^ code[2] ^ code[5] ^ code[6];
        s3 = code[3] ^ code[4] ^ code[5] ^ code[6];
        return {s3, s2, s1};
    endfunction

endpackage

// File: rtl/hamming_serial_rx_syndrome.sv
// Combinational Hamming(7,4) single-error correction: syndrome, fixed code
// word and extracted data nibble.
module hamm_syndrome
    import hamming_serial_rx_pkg::*;
(
    input  logic [CODE_LEN-1:0] code,
    output logic [DATA_W-1:0]   data,
    output logic [2:0]          syndrome,
    output logic                corrected
);

    logic [CODE_LEN-1:0] fixed_s;

    // The syndrome names the erroneous position directly (0 means clean).
    always_comb begin
        syndrome  = calc_syndrome(code);
        corrected = (syndrome != 3'd0);
        for (int i = 0; i < CODE_LEN; i++) begin
            fixed_s[i] = code[i] ^ (syndrome == 3'(i + 1));
        end
        data = {fixed_s[D4_IDX], fixed_s[D3_IDX], fixed_s[D2_IDX], fixed_s[D1_IDX]};
    end

endmodule

// File: rtl/hamming_serial_rx.sv
// Serial Hamming(7,4) frame receiver with single-entry output buffer,
// overrun/framing pulses and saturating error counters.
module hamming_serial_rx
    import hamming_serial_rx_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_en,
    input  logic             serial_in,
    output logic [3:0]       data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             corrected,
    output logic             frame_err,
    output logic             overrun,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] ferr_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    rx_state_t           state_r;
    rx_state_t           state_next_s;
    logic [2:0]          bit_cnt_r;
    logic [CODE_LEN-1:0] code_r;
    logic [DATA_W-1:0]   data_out_r;
    logic                data_valid_r;
    logic                corrected_r;
    logic                frame_err_r;
    logic                overrun_r;
    logic [CNT_W-1:0]    corr_cnt_r;
    logic [CNT_W-1:0]    ferr_cnt_r;
    logic [DATA_W-1:0]   dec_data_s;
    logic [2:0]          dec_syn_s;
    logic                dec_corr_s;
    logic                word_done_s;
    logic                stop_err_s;
    logic                accept_s;
    logic                load_s;

    hamm_syndrome u_syndrome (
        .code      (code_r),
        .data      (dec_data_s),
        .syndrome  (dec_syn_s),
        .corrected (dec_corr_s)
    );

    assign accept_s = data_valid_r & data_ready;
    assign load_s   = word_done_s & (~data_valid_r | data_ready);

    // FSM next state plus stop-bit completion/error decode.
    always_comb begin
        state_next_s = state_r;
        word_done_s  = 1'b0;
        stop_err_s   = 1'b0;
        if (bit_en) begin
            case (state_r)
                ST_IDLE: begin
                    if (!serial_in) begin
                        state_next_s = ST_DATA;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_DATA: begin
                    if (bit_cnt_r == 3'(CODE_LEN - 1)) begin
                        state_next_s = ST_STOP;
                    end else begin
                        state_next_s = ST_DATA;
                    end
                end
                ST_STOP: begin
                    if (serial_in) begin
                        state_next_s = ST_IDLE;
                        word_done_s  = 1'b1;
                    end else begin
                        state_next_s = ST_WAIT_IDLE;
                        stop_err_s   = 1'b1;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (serial_in) begin
                        state_next_s = ST_IDLE;
                    end else begin
                        state_next_s = ST_WAIT_IDLE;
                    end
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end else begin
            state_next_s = state_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Bit counter and code shift register, advanced only on strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt_r <= 3'd0;
            code_r    <= {CODE_LEN{1'b0}};
        end else if (bit_en) begin
            case (state_r)
                ST_IDLE: begin
                    bit_cnt_r <= 3'd0;
                end
                ST_DATA: begin
                    code_r[bit_cnt_r] <= serial_in;
                    bit_cnt_r         <= bit_cnt_r + 3'd1;
                end
                default: begin
                    bit_cnt_r <= bit_cnt_r;
                end
            endcase
        end else begin
            bit_cnt_r <= bit_cnt_r;
        end
    end

    // Output buffer, status pulses and saturating counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_r   <= {DATA_W{1'b0}};
            data_valid_r <= 1'b0;
            corrected_r  <= 1'b0;
            frame_err_r  <= 1'b0;
            overrun_r    <= 1'b0;
            corr_cnt_r   <= {CNT_W{1'b0}};
            ferr_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            frame_err_r <= stop_err_s;
            overrun_r   <= word_done_s & ~load_s;
            if (load_s) begin
                data_out_r   <= dec_data_s;
                corrected_r  <= dec_corr_s;
                data_valid_r <= 1'b1;
            end else if (accept_s) begin
                data_valid_r <= 1'b0;
            end else begin
                data_valid_r <= data_valid_r;
            end
            // Dropped words still count toward corrections.
            if (word_done_s && (dec_syn_s != 3'd0) && (corr_cnt_r != CNT_MAX)) begin
                corr_cnt_r <= corr_cnt_r + CNT_ONE;
            end else begin
                corr_cnt_r <= corr_cnt_r;
            end
            if (stop_err_s && (ferr_cnt_r != CNT_MAX)) begin
                ferr_cnt_r <= ferr_cnt_r + CNT_ONE;
            end else begin
                ferr_cnt_r <= ferr_cnt_r;
            end
        end
    end

    assign data_out   = data_out_r;
    assign data_valid = data_valid_r;
    assign corrected  = corrected_r;
    assign frame_err  = frame_err_r;
    assign overrun    = overrun_r;
    assign corr_cnt   = corr_cnt_r;
    assign ferr_cnt   = ferr_cnt_r;

endmodule

// File: tb/tb_hamming_serial_rx.sv
// Directed bench for hamming_serial_rx: frame-level reference model checked
// every cycle, plus hand-computed literal expectations.
module tb_hamming_serial_rx;

    localparam int CNT_W   = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             bit_en = 1'b0;
    logic             serial_in = 1'b1;
    logic             data_ready = 1'b1;
    logic [3:0]       data_out;
    logic             data_valid;
    logic             corrected;
    logic             frame_err;
    logic             overrun;
    logic [CNT_W-1:0] corr_cnt;
    logic [CNT_W-1:0] ferr_cnt;

    int checks = 0;
    int failures = 0;

    hamming_serial_rx #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .corrected  (corrected),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .corr_cnt   (corr_cnt),
        .ferr_cnt   (ferr_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference decode: the syndrome is the XOR of the positions of all set bits.
    task automatic ref_decode(input logic [6:0] c, output logic [3:0] d, output int syn);
        syn = 0;
        for (int i = 0; i < 7; i++) begin
            if (c[i]) syn = syn ^ (i + 1);
        end
        if (syn != 0) c[syn-1] = ~c[syn-1];
        d = {c[6], c[5], c[4], c[2]};
    endtask

    // Model: phase -1 idle, 0..6 data bit index, 7 stop, 8 waiting for idle.
    int         m_phase = -1;
    logic [6:0] m_code = 7'd0;
    logic       m_valid = 1'b0;
    logic       m_corr = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_ovr = 1'b0;
    logic [3:0] m_data = 4'd0;
    int         m_ccnt = 0;
    int         m_fcnt = 0;
    logic [3:0] m_d;
    int         m_syn;
    bit         m_done;

    always @(posedge clk) begin
        if (rst) begin
            m_phase = -1; m_code = 7'd0; m_valid = 1'b0; m_corr = 1'b0;
            m_ferr = 1'b0; m_ovr = 1'b0; m_data = 4'd0; m_ccnt = 0; m_fcnt = 0;
        end else begin
            m_ferr = 1'b0;
            m_ovr = 1'b0;
            m_done = 1'b0;
            if (bit_en) begin
                if (m_phase < 0) begin
                    if (!serial_in) m_phase = 0;
                end else if (m_phase < 7) begin
                    m_code[m_phase] = serial_in;
                    m_phase++;
                end else if (m_phase == 7) begin
                    if (serial_in) begin
                        m_done = 1'b1;
                        m_phase = -1;
                    end else begin
                        m_ferr = 1'b1;
                        if (m_fcnt < CNT_MAX) m_fcnt++;
                        m_phase = 8;
                    end
                end else if (serial_in) begin
                    m_phase = -1;
                end
            end
            if (m_done) begin
                ref_decode(m_code, m_d, m_syn);
                if (m_syn != 0 && m_ccnt < CNT_MAX) m_ccnt++;
                if (!m_valid || data_ready) begin
                    m_valid = 1'b1;
                    m_data = m_d;
                    m_corr = (m_syn != 0);
                end else begin
                    m_ovr = 1'b1;
                end
            end else if (m_valid && data_ready) begin
                m_valid = 1'b0;
            end
        end
        #1;
        check("model_valid", 32'(data_valid), 32'(m_valid));
        if (m_valid) begin
            check("model_data", 32'(data_out), 32'(m_data));
            check("model_corrected", 32'(corrected), 32'(m_corr));
        end
        check("model_frame_err", 32'(frame_err), 32'(m_ferr));
        check("model_overrun", 32'(overrun), 32'(m_ovr));
        check("model_corr_cnt", 32'(corr_cnt), 32'(m_ccnt));
        check("model_ferr_cnt", 32'(ferr_cnt), 32'(m_fcnt));
    end

    // One strobed bit, followed by a gap cycle with the line inverted.
    task automatic strobe(input logic b);
        @(negedge clk);
        bit_en = 1'b1;
        serial_in = b;
        @(negedge clk);
        bit_en = 1'b0;
        serial_in = ~b;
    endtask

    task automatic send_frame(input logic [6:0] code, input logic stop);
        strobe(1'b0);
        for (int i = 0; i < 7; i++) strobe(code[i]);
        strobe(stop);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data_out"}, 32'(data_out), 32'd0);
        check({tag, "_valid"}, 32'(data_valid), 32'd0);
        check({tag, "_corrected"}, 32'(corrected), 32'd0);
        check({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check({tag, "_overrun"}, 32'(overrun), 32'd0);
        check({tag, "_corr_cnt"}, 32'(corr_cnt), 32'd0);
        check({tag, "_ferr_cnt"}, 32'(ferr_cnt), 32'd0);
    endtask

    logic [6:0] one_hot;

    initial begin
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_all_zero("reset");

        // Clean codeword, consumer ready.
        data_ready = 1'b1;
        send_frame(7'b1010101, 1'b1);
        check("clean_valid", 32'(data_valid), 32'd1);
        check("clean_data", 32'(data_out), 32'hB);
        check("clean_corrected", 32'(corrected), 32'd0);
        @(negedge clk);
        check("clean_valid_one_cycle", 32'(data_valid), 32'd0);

        // Position 5 flipped.
        send_frame(7'b1000101, 1'b1);
        check("corr_data", 32'(data_out), 32'hB);
        check("corr_flag", 32'(corrected), 32'd1);
        check("corr_cnt_1", 32'(corr_cnt), 32'd1);

        // Bad stop bit, line low, recover, clean frame.
        send_frame(7'b1010101, 1'b0);
        check("ferr_pulse", 32'(frame_err), 32'd1);
        check("ferr_cnt_1", 32'(ferr_cnt), 32'd1);
        check("ferr_no_valid", 32'(data_valid), 32'd0);
        @(negedge clk);
        check("ferr_single_pulse", 32'(frame_err), 32'd0);
        repeat (3) strobe(1'b0);
        strobe(1'b1);
        send_frame(7'b0110011, 1'b1);
        check("recover_valid", 32'(data_valid), 32'd1);
        check("recover_data", 32'(data_out), 32'h6);
        check("recover_ferr_cnt", 32'(ferr_cnt), 32'd1);

        // Overrun: second (corrected) word dropped, first held.
        @(negedge clk);
        data_ready = 1'b0;
        send_frame(7'b1010101, 1'b1);
        check("hold_valid", 32'(data_valid), 32'd1);
        check("hold_data", 32'(data_out), 32'hB);
        send_frame(7'b0110001, 1'b1);
        check("overrun_pulse", 32'(overrun), 32'd1);
        check("overrun_keeps_data", 32'(data_out), 32'hB);
        check("overrun_valid", 32'(data_valid), 32'd1);
        check("overrun_corr_cnt", 32'(corr_cnt), 32'd2);
        @(negedge clk);
        check("overrun_single_pulse", 32'(overrun), 32'd0);
        data_ready = 1'b1;
        @(negedge clk);
        check("drain_valid", 32'(data_valid), 32'd0);

        // Reset mid-frame after 4 data bits.
        strobe(1'b0);
        for (int i = 0; i < 4; i++) strobe(i[0]);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_all_zero("midreset");
        send_frame(7'b1000101, 1'b1);
        check("postreset_data", 32'(data_out), 32'hB);
        check("postreset_corr", 32'(corrected), 32'd1);
        check("postreset_corr_cnt", 32'(corr_cnt), 32'd1);

        // Corrected-count saturation.
        for (int k = 0; k < 300; k++) begin
            one_hot = 7'd1 << (k % 7);
            send_frame(7'b1010101 ^ one_hot, 1'b1);
            if (k == 252) check("corr_cnt_254", 32'(corr_cnt), 32'd254);
        end
        check("corr_cnt_sat", 32'(corr_cnt), 32'd255);

        repeat (3) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
